// File: rtl/stack_queue_buffer.sv
// Dual-mode LIFO/FIFO operand store on a ring buffer with occupancy count and sticky error flags.
// Optional peek read port enabled by defining SQB_PEEK_EN.
module stack_queue_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic              mode,
    input  logic [DATA_W-1:0] data_in,
`ifdef SQB_PEEK_EN
    input  logic [ADDR_W-1:0] peek_idx,
    output logic [DATA_W-1:0] peek_data,
`endif
    output logic [DATA_W-1:0] stack_top,
    output logic [DATA_W-1:0] queue_head,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] head_q, head_d, base_q, base_d, top_addr, wr_addr;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;
    logic              wr_en;

    assign top_addr = head_q - ADDR_W'(1);
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));

    always_comb begin
        head_d      = head_q;
        base_d      = base_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_en       = 1'b0;
        wr_addr     = head_q;
        if (clear) begin
            head_d      = '0;
            base_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (push && pop && !empty) begin
            // Occupancy is unchanged, so this is legal even when full.
            wr_en = 1'b1;
            if (mode) begin
                head_d = head_q + ADDR_W'(1);
                base_d = base_q + ADDR_W'(1);
            end else begin
                wr_addr = top_addr;
            end
        end else if (push) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                head_d  = head_q + ADDR_W'(1);
                count_d = count_q + CNT_W'(1);
            end
            // Reaching here with pop set means the buffer was empty.
            if (pop) underflow_d = 1'b1;
        end else if (pop) begin
            if (empty) begin
                underflow_d = 1'b1;
            end else begin
                count_d = count_q - CNT_W'(1);
                if (mode) base_d = base_q + ADDR_W'(1);
                else      head_d = top_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q      <= '0;
            base_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            base_q      <= base_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= data_in;
    end

    assign stack_top  = empty ? '0 : mem[top_addr];
    assign queue_head = empty ? '0 : mem[base_q];
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

`ifdef SQB_PEEK_EN
    logic [ADDR_W-1:0] peek_addr;
    assign peek_addr = mode ? (base_q + peek_idx) : (top_addr - peek_idx);
    assign peek_data = ({1'b0, peek_idx} < count_q) ? mem[peek_addr] : '0;
`endif

endmodule

// File: tb/tb_stack_queue_buffer.sv
// Scoreboard bench for stack_queue_buffer at DEPTH=4, DATA_W=8; stimulus queues expectations,
// a monitor compares them just after the clock edge they apply to.
module tb_stack_queue_buffer;
    logic       clk = 1'b0;
    logic       rst, clear, push, pop, mode;
    logic [7:0] data_in, stack_top, queue_head;
    logic [2:0] count;
    logic       empty, full, overflow, underflow;
`ifdef SQB_PEEK_EN
    logic [1:0] peek_idx;
    logic [7:0] peek_data;
`endif

    stack_queue_buffer #(.DATA_W(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .push       (push),
        .pop        (pop),
        .mode       (mode),
        .data_in    (data_in),
`ifdef SQB_PEEK_EN
        .peek_idx   (peek_idx),
        .peek_data  (peek_data),
`endif
        .stack_top  (stack_top),
        .queue_head (queue_head),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] st;
        logic [7:0] qh;
        logic [2:0] cnt;
        logic       ov;
        logic       un;
        logic       pk_en;
        logic [7:0] pk;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string nm, input string fld, input logic [7:0] got,
                         input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h want %0h", nm, fld, got, want);
        end
    endtask

    // Monitor: compares the queued expectation against outputs settled after the edge.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, "stack_top", stack_top, e.st);
                check(n, "queue_head", queue_head, e.qh);
                check(n, "count", {5'b0, count}, {5'b0, e.cnt});
                check(n, "empty", {7'b0, empty}, {7'b0, e.cnt == 3'd0});
                check(n, "full", {7'b0, full}, {7'b0, e.cnt == 3'd4});
                check(n, "overflow", {7'b0, overflow}, {7'b0, e.ov});
                check(n, "underflow", {7'b0, underflow}, {7'b0, e.un});
`ifdef SQB_PEEK_EN
                if (e.pk_en) check(n, "peek_data", peek_data, e.pk);
`endif
            end
        end
    end

    task automatic expect_state(input string nm, input logic [7:0] st, input logic [7:0] qh,
                                input int cnt, input logic ov, input logic un,
                                input logic pk_en, input logic [7:0] pk);
        exp_t e;
        e.st = st; e.qh = qh; e.cnt = 3'(cnt); e.ov = ov; e.un = un;
        e.pk_en = pk_en; e.pk = pk;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step(input logic cl, input logic pu, input logic po, input logic md,
                        input logic [7:0] d, input string nm, input logic [7:0] st,
                        input logic [7:0] qh, input int cnt, input logic ov, input logic un);
        @(negedge clk);
        clear = cl; push = pu; pop = po; mode = md; data_in = d;
        expect_state(nm, st, qh, cnt, ov, un, 1'b0, 8'h00);
    endtask

`ifdef SQB_PEEK_EN
    task automatic peek_step(input logic md, input logic [1:0] idx, input string nm,
                             input logic [7:0] pk);
        @(negedge clk);
        clear = 1'b0; push = 1'b0; pop = 1'b0; mode = md; data_in = 8'h00; peek_idx = idx;
        expect_state(nm, 8'h03, 8'h01, 3, 1'b0, 1'b0, 1'b1, pk);
    endtask
`endif

    initial begin
        logic [7:0] v;
        rst = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; mode = 1'b0; data_in = 8'h00;
`ifdef SQB_PEEK_EN
        peek_idx = 2'd0;
`endif
        @(negedge clk);
        expect_state("in_reset", 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        expect_state("after_reset", 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Basic push, then mixed stack/queue pops
        step(0, 1, 0, 0, 8'h11, "push1", 8'h11, 8'h11, 1, 0, 0);
        step(0, 1, 0, 0, 8'h22, "push2", 8'h22, 8'h11, 2, 0, 0);
        step(0, 1, 0, 0, 8'h33, "push3", 8'h33, 8'h11, 3, 0, 0);
        step(0, 0, 1, 0, 8'h00, "stack_pop", 8'h22, 8'h11, 2, 0, 0);
        step(0, 0, 1, 1, 8'h00, "queue_pop", 8'h22, 8'h22, 1, 0, 0);
        step(0, 0, 1, 1, 8'h00, "queue_pop_last", 8'h00, 8'h00, 0, 0, 0);

        // Fill, overflow, then push+pop while full in queue mode
        step(0, 1, 0, 0, 8'ha1, "fill1", 8'ha1, 8'ha1, 1, 0, 0);
        step(0, 1, 0, 0, 8'ha2, "fill2", 8'ha2, 8'ha1, 2, 0, 0);
        step(0, 1, 0, 0, 8'ha3, "fill3", 8'ha3, 8'ha1, 3, 0, 0);
        step(0, 1, 0, 0, 8'ha4, "fill4", 8'ha4, 8'ha1, 4, 0, 0);
        step(0, 1, 0, 0, 8'h55, "overflow", 8'ha4, 8'ha1, 4, 1, 0);
        step(0, 1, 1, 1, 8'hb5, "full_qpushpop", 8'hb5, 8'ha2, 4, 1, 0);
        step(1, 0, 0, 0, 8'h00, "clear_full", 8'h00, 8'h00, 0, 0, 0);

        // Stack replace-top, then push+pop on empty
        step(0, 1, 0, 0, 8'hc1, "spush1", 8'hc1, 8'hc1, 1, 0, 0);
        step(0, 1, 0, 0, 8'hc2, "spush2", 8'hc2, 8'hc1, 2, 0, 0);
        step(0, 1, 1, 0, 8'h99, "stack_replace", 8'h99, 8'hc1, 2, 0, 0);
        step(0, 0, 1, 0, 8'h00, "spop1", 8'hc1, 8'hc1, 1, 0, 0);
        step(0, 0, 1, 0, 8'h00, "spop2", 8'h00, 8'h00, 0, 0, 0);
        step(0, 1, 1, 0, 8'h77, "empty_pushpop", 8'h77, 8'h77, 1, 0, 1);
        step(0, 0, 1, 0, 8'h00, "spop3", 8'h00, 8'h00, 0, 0, 1);
        step(1, 1, 0, 0, 8'hee, "clear_beats_push", 8'h00, 8'h00, 0, 0, 0);

        // FIFO order across pointer wrap
        step(0, 1, 0, 1, 8'h10, "wrap_push0", 8'h10, 8'h10, 1, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            v = 8'h10 + 8'(i);
            step(0, 1, 0, 1, v, "wrap_push", v, v - 8'h01, 2, 0, 0);
            step(0, 0, 1, 1, 8'h00, "wrap_pop", v, v, 1, 0, 0);
        end
        step(0, 0, 1, 1, 8'h00, "wrap_drain", 8'h00, 8'h00, 0, 0, 0);
        step(0, 0, 1, 1, 8'h00, "queue_underflow", 8'h00, 8'h00, 0, 0, 1);
        step(1, 0, 0, 1, 8'h00, "clear_flags", 8'h00, 8'h00, 0, 0, 0);

        // Mode switch with data held
        step(0, 1, 0, 0, 8'h01, "mix1", 8'h01, 8'h01, 1, 0, 0);
        step(0, 1, 0, 0, 8'h02, "mix2", 8'h02, 8'h01, 2, 0, 0);
        step(0, 1, 0, 0, 8'h03, "mix3", 8'h03, 8'h01, 3, 0, 0);
        step(0, 0, 1, 1, 8'h00, "mix_qpop", 8'h03, 8'h02, 2, 0, 0);
        step(1, 0, 0, 0, 8'h00, "clear_mix", 8'h00, 8'h00, 0, 0, 0);

`ifdef SQB_PEEK_EN
        step(0, 1, 0, 0, 8'h01, "pk_push1", 8'h01, 8'h01, 1, 0, 0);
        step(0, 1, 0, 0, 8'h02, "pk_push2", 8'h02, 8'h01, 2, 0, 0);
        step(0, 1, 0, 0, 8'h03, "pk_push3", 8'h03, 8'h01, 3, 0, 0);
        peek_step(1'b0, 2'd2, "peek_stack2", 8'h01);
        peek_step(1'b1, 2'd2, "peek_queue2", 8'h03);
        peek_step(1'b1, 2'd3, "peek_beyond", 8'h00);
`endif

        @(negedge clk);
        clear = 1'b0; push = 1'b0; pop = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
